// File: rtl/board_io_ctrl_if.sv
// board_io_ctrl_if: picorv32 native bus port of the board I/O controller.
interface board_io_ctrl_if;
  logic        bus_valid;
  logic        bus_ready;
  logic [4:0]  bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  modport master (output bus_valid, bus_addr, bus_wstrb, bus_wdata, input bus_ready, bus_rdata);
  modport slave (input bus_valid, bus_addr, bus_wstrb, bus_wdata, output bus_ready, bus_rdata);
endinterface

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: debounced buttons with press/release events and irq, plus
// per-LED off/on/follow/PWM control, memory-mapped on the picorv32 native bus.
module board_io_ctrl #(
  parameter int NUM_BUTTONS       = 2,
  parameter int NUM_LEDS          = 2,
  parameter int DEBOUNCE_CYCLES   = 12000,
  parameter int PWM_BITS          = 8,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_in,
  output logic [NUM_LEDS-1:0]    leds_out,
  output logic                   irq,
  board_io_ctrl_if.slave         bus
);
  localparam int NB = NUM_BUTTONS;
  localparam int NL = NUM_LEDS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB-1:0] SYNC_IDLE = {NB{BUTTON_ACTIVE_LOW}};
  localparam logic [NB-1:0] ONE = 1;
  localparam logic [31:0] BTN_M = (32'd1 << NB) - 32'd1;
  localparam logic [31:0] EVT_M = BTN_M | (BTN_M << 16);
  localparam logic [31:0] MODE_M = (32'd1 << (2 * NL)) - 32'd1;

  function automatic logic [31:0] duty_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NL; i++) m |= ((32'd1 << PWM_BITS) - 32'd1) << (8 * i);
    return m;
  endfunction

  function automatic logic [31:0] mode_reset();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NL; i++) if (i < NB) m |= 32'd2 << (2 * i);
    return m;
  endfunction

  function automatic logic [31:0] wmerge(logic [31:0] old, logic [31:0] d, logic [31:0] wm,
                                         logic [31:0] m);
    return ((old & ~wm) | (d & wm)) & m;
  endfunction

  localparam logic [31:0] DUTY_M = duty_mask();
  localparam logic [31:0] MODE_RST = mode_reset();

  logic [NB-1:0]         sync1_q, sync2_q, stable_q, stable_d, pressed;
  logic [NB-1:0][CW-1:0] cnt_q, cnt_d;
  logic [31:0]           evt_q, evt_d, ien_q, ien_d, mode_q, mode_d, duty_q, duty_d;
  logic [31:0]           rdata_q, rdata_d, wdata_q, wmask, clr;
  logic [3:0]            wstrb_q;
  logic [2:0]            waddr_q;
  logic                  wr_q, ready_q, irq_q, accept, unused_addr;
  logic [NL-1:0]         led_q, led_d;
  logic [PWM_BITS-1:0]   pwm_q;

  assign accept      = bus.bus_valid && !ready_q;
  assign pressed     = BUTTON_ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign wmask       = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign clr         = (wr_q && waddr_q == 3'd1) ? (wdata_q & wmask) : 32'd0;
  assign unused_addr = ^bus.bus_addr[1:0];
  assign bus.bus_ready = ready_q;
  assign bus.bus_rdata = rdata_q;
  assign leds_out    = led_q;
  assign irq         = irq_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < NB; i++) begin
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = pressed[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Set terms are OR-ed in after the W1C clear so a new event always survives.
  always_comb begin
    evt_d  = ((evt_q & ~clr) | 32'(stable_d & ~stable_q) | (32'(stable_q & ~stable_d) << 16)) & EVT_M;
    ien_d  = (wr_q && waddr_q == 3'd2) ? wmerge(ien_q, wdata_q, wmask, EVT_M) : ien_q;
    mode_d = (wr_q && waddr_q == 3'd3) ? wmerge(mode_q, wdata_q, wmask, MODE_M) : mode_q;
    duty_d = (wr_q && waddr_q == 3'd4) ? wmerge(duty_q, wdata_q, wmask, DUTY_M) : duty_q;
    rdata_d = !accept                      ? 32'd0 :
              bus.bus_addr[4:2] == 3'd0    ? 32'(stable_q) :
              bus.bus_addr[4:2] == 3'd1    ? evt_q :
              bus.bus_addr[4:2] == 3'd2    ? ien_q :
              bus.bus_addr[4:2] == 3'd3    ? mode_q :
              bus.bus_addr[4:2] == 3'd4    ? duty_q : 32'd0;
    led_d = '0;
    for (int i = 0; i < NL; i++)
      led_d[i] = mode_q[2*i +: 2] == 2'b00 ? 1'b0 :
                 mode_q[2*i +: 2] == 2'b01 ? 1'b1 :
                 mode_q[2*i +: 2] == 2'b10 ? |(stable_q & (ONE << i)) :
                 (pwm_q < duty_q[8*i +: PWM_BITS]);
  end

  // Write data is captured on acceptance and committed one edge later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= SYNC_IDLE;
      sync2_q  <= SYNC_IDLE;
      stable_q <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      ien_q    <= '0;
      mode_q   <= MODE_RST & MODE_M;
      duty_q   <= '0;
      rdata_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      waddr_q  <= '0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b0;
      irq_q    <= 1'b0;
      led_q    <= '0;
      pwm_q    <= '0;
    end else begin
      sync1_q  <= buttons_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      ien_q    <= ien_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      rdata_q  <= rdata_d;
      wdata_q  <= bus.bus_wdata;
      wstrb_q  <= bus.bus_wstrb;
      waddr_q  <= bus.bus_addr[4:2];
      wr_q     <= accept && |bus.bus_wstrb;
      ready_q  <= accept;
      irq_q    <= |(evt_q & ien_q);
      led_q    <= led_d;
      pwm_q    <= pwm_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed checks of debounce, events/irq, LED modes and bus corners.
module tb_board_io_ctrl;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] buttons_in = 2'b11;
  logic [1:0] leds_out;
  logic       irq;
  int         n_cmp = 0;
  int         n_fail = 0;

  board_io_ctrl_if bus ();

  board_io_ctrl #(
    .NUM_BUTTONS(2), .NUM_LEDS(2), .DEBOUNCE_CYCLES(4), .PWM_BITS(8), .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .buttons_in(buttons_in),
    .leds_out(leds_out), .irq(irq), .bus(bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic bus_write(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
    int n = 0;
    bus.bus_valid = 1'b1; bus.bus_addr = a; bus.bus_wstrb = s; bus.bus_wdata = d;
    do begin @(posedge clock); #1; n++; end while (!bus.bus_ready && n < 8);
    if (!bus.bus_ready) begin n_cmp++; n_fail++; $display("FAIL bus_write_timeout addr=%h", a); end
    bus.bus_valid = 1'b0; bus.bus_wstrb = 4'd0;
    @(posedge clock); #1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    bus.bus_valid = 1'b1; bus.bus_addr = a; bus.bus_wstrb = 4'd0; bus.bus_wdata = '0;
    do begin @(posedge clock); #1; n++; end while (!bus.bus_ready && n < 8);
    if (!bus.bus_ready) begin n_cmp++; n_fail++; $display("FAIL bus_read_timeout addr=%h", a); end
    d = bus.bus_rdata;
    bus.bus_valid = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({bus.bus_ready, irq, leds_out} !== 4'b0) begin n_fail++;
      $display("FAIL reset_outputs: got ready/irq/leds=%b want 0000", {bus.bus_ready, irq, leds_out}); end
    n_cmp++; if (bus.bus_rdata !== 32'd0) begin n_fail++;
      $display("FAIL reset_rdata: got %h want 0", bus.bus_rdata); end
    reset_n = 1'b1;
    bus_read(5'h0C, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL reset_led_mode: got %h want 0000000a", d); end
    bus_read(5'h00, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_btn_state: got %h want 0", d); end
  endtask

  task automatic test_follow();
    logic [31:0] d;
    @(posedge clock); #1;
    buttons_in[0] = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++; if (leds_out[0] !== 1'b0) begin n_fail++; $display("FAIL follow_early: got led0=%b want 0", leds_out[0]); end
    @(posedge clock); #1;
    n_cmp++; if (leds_out[0] !== 1'b1) begin n_fail++; $display("FAIL follow_7cyc: got led0=%b want 1", leds_out[0]); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL follow_event: got %h want 00000001", d); end
    bus_read(5'h00, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL follow_state: got %h want 00000001", d); end
    buttons_in[0] = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    n_cmp++; if (leds_out[0] !== 1'b0) begin n_fail++; $display("FAIL follow_release: got led0=%b want 0", leds_out[0]); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL follow_events: got %h want 00010001", d); end
    bus_write(5'h04, 4'hF, 32'h0001_0001);
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL w1c_all: got %h want 0", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic        irq_seen = 1'b0;
    bus_write(5'h08, 4'hF, 32'hFFFF_FFFF);
    bus_read(5'h08, d);
    n_cmp++; if (d !== 32'h0003_0003) begin n_fail++; $display("FAIL irq_en_mask: got %h want 00030003", d); end
    @(posedge clock); #1;
    buttons_in[1] = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    buttons_in[1] = 1'b1;
    repeat (12) begin @(posedge clock); #1; irq_seen |= irq; end
    n_cmp++; if (irq_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_irq: got irq=1 want 0"); end
    bus_read(5'h00, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL glitch_state: got %h want 0", d); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL glitch_event: got %h want 0", d); end
  endtask

  task automatic test_events_irq();
    logic [31:0] d;
    bus_write(5'h08, 4'hF, 32'h0001_0000);
    buttons_in[0] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_on_press: got irq=%b want 0", irq); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL press_event: got %h want 00000001", d); end
    buttons_in[0] = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got irq=%b want 0", irq); end
    @(posedge clock); #1;
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_release: got irq=%b want 1", irq); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL release_events: got %h want 00010001", d); end
    bus_write(5'h04, 4'hF, 32'h0001_0000);
    @(posedge clock); #1;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got irq=%b want 0", irq); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL w1c_release: got %h want 00000001", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    @(posedge clock); #1;
    buttons_in[0] = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    bus.bus_valid = 1'b1; bus.bus_addr = 5'h04; bus.bus_wstrb = 4'hF; bus.bus_wdata = 32'h1;
    @(posedge clock); #1;
    n_cmp++; if (bus.bus_ready !== 1'b1) begin n_fail++; $display("FAIL collide_ready: got %b want 1", bus.bus_ready); end
    bus.bus_valid = 1'b0; bus.bus_wstrb = 4'd0;
    @(posedge clock); #1;
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL collide_set_wins: got %h want 00000001", d); end
    buttons_in[0] = 1'b1;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    int cnt;
    logic led1_seen;
    bus_write(5'h0C, 4'hF, 32'hFFFF_FFFF);
    bus_read(5'h0C, d);
    n_cmp++; if (d !== 32'h0000_000F) begin n_fail++; $display("FAIL mode_mask: got %h want 0000000f", d); end
    bus_write(5'h0C, 4'hF, 32'h3);
    bus_write(5'h10, 4'hF, 32'd64);
    cnt = 0; led1_seen = 1'b0;
    repeat (256) begin @(posedge clock); #1; cnt += int'(leds_out[0]); led1_seen |= leds_out[1]; end
    n_cmp++; if (cnt != 64) begin n_fail++; $display("FAIL pwm_64: got %0d lit want 64", cnt); end
    n_cmp++; if (led1_seen !== 1'b0) begin n_fail++; $display("FAIL led1_off: got lit want dark"); end
    bus_write(5'h10, 4'b0010, 32'hAAAA_55CC);
    bus_read(5'h10, d);
    n_cmp++; if (d !== 32'h0000_5540) begin n_fail++; $display("FAIL duty_wstrb: got %h want 00005540", d); end
    bus_write(5'h10, 4'hF, 32'h0000_5500);
    cnt = 0;
    repeat (256) begin @(posedge clock); #1; cnt += int'(leds_out[0]); end
    n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL pwm_0: got %0d lit want 0", cnt); end
    bus_write(5'h10, 4'hF, 32'h0000_55FF);
    cnt = 0;
    repeat (256) begin @(posedge clock); #1; cnt += int'(leds_out[0]); end
    n_cmp++; if (cnt != 255) begin n_fail++; $display("FAIL pwm_255: got %0d lit want 255", cnt); end
    bus_write(5'h0C, 4'hF, 32'h7);
    n_cmp++; if (leds_out[1] !== 1'b0) begin n_fail++; $display("FAIL mode_latency_early: got %b want 0", leds_out[1]); end
    @(posedge clock); #1;
    n_cmp++; if (leds_out[1] !== 1'b1) begin n_fail++; $display("FAIL mode_latency: got %b want 1", leds_out[1]); end
  endtask

  task automatic test_bus_corner();
    logic [31:0] d;
    bus.bus_valid = 1'b1; bus.bus_addr = 5'h18; bus.bus_wstrb = 4'd0;
    @(posedge clock); #1;
    n_cmp++; if (bus.bus_ready !== 1'b1 || bus.bus_rdata !== 32'd0) begin n_fail++;
      $display("FAIL read_18: got ready=%b rdata=%h want 1/0", bus.bus_ready, bus.bus_rdata); end
    @(posedge clock); #1;
    n_cmp++; if (bus.bus_ready !== 1'b0) begin n_fail++; $display("FAIL ready_pulse: got %b want 0", bus.bus_ready); end
    bus.bus_valid = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (bus.bus_ready !== 1'b0) begin n_fail++; $display("FAIL ready_idle: got %b want 0", bus.bus_ready); end
    bus_write(5'h18, 4'hF, 32'hFFFF_FFFF);
    bus_read(5'h18, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL write_18_ignored: got %h want 0", d); end
    bus_read(5'h13, d);
    n_cmp++; if (d !== 32'h0000_55FF) begin n_fail++; $display("FAIL addr_low_ignored: got %h want 000055ff", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ready_seen = 1'b0;
    bus_write(5'h08, 4'hF, 32'h0001_0000);
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({irq, leds_out[1]} !== 2'b11) begin n_fail++; $display("FAIL pre_reset: got irq/led1=%b want 11", {irq, leds_out[1]}); end
    bus.bus_valid = 1'b1; bus.bus_addr = 5'h0C; bus.bus_wstrb = 4'd0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.bus_ready, irq, leds_out} !== 4'b0 || bus.bus_rdata !== 32'd0) begin n_fail++;
      $display("FAIL mid_reset_outputs: got ready/irq/leds=%b rdata=%h want 0", {bus.bus_ready, irq, leds_out}, bus.bus_rdata); end
    repeat (3) begin @(posedge clock); #1; ready_seen |= bus.bus_ready; end
    n_cmp++; if (ready_seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got 1 want 0"); end
    bus.bus_valid = 1'b0;
    reset_n = 1'b1;
    bus_read(5'h0C, d);
    n_cmp++; if (d !== 32'h0000_000A) begin n_fail++; $display("FAIL post_reset_mode: got %h want 0000000a", d); end
    bus_read(5'h04, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL post_reset_event: got %h want 0", d); end
    bus_read(5'h10, d);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL post_reset_duty: got %h want 0", d); end
  endtask

  initial begin
    bus.bus_valid = 1'b0; bus.bus_addr = '0; bus.bus_wstrb = '0; bus.bus_wdata = '0;
    test_reset();
    test_follow();
    test_glitch();
    test_events_irq();
    test_collision();
    test_pwm();
    test_bus_corner();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
